debounce_array: RTL and testbench
=================================

# debounce_array

Parametrised, multi-channel debouncer replacing the fixed 4-switch/5-button filter that sits between the board pins and the game control logic. Each channel synchronises its raw pin, then accepts a new level only after the input has held that level for a programmable number of consecutive clocks. Each channel also produces single-cycle press/release pulses. An optional auto-repeat pulse per channel supports held-button actions. One instance serves all switches and buttons, clocked by the 2 kHz main clock.

## Interface
- N_CH, 9: number of channels (default covers 4 switches + 5 buttons).
- STABLE_CNT, 20: consecutive stable cycles required to accept a new level (10 ms at 2 kHz); legal range ≥1.
- RESET_LEVEL, {N_CH{1'b0}}: per-channel value loaded into the synchroniser and level_o on reset.
- REPEAT_DELAY, 1000: cycles from accepted rise to first repeat pulse; ≥1; used only with repeat compiled in.
- REPEAT_PERIOD, 200: cycles between subsequent repeat pulses; ≥1; used only with repeat compiled in.

Ports:
- main_clk  in  1  system clock (2 kHz).
- rst_n  in  1  reset; asynchronous, active-low.
- raw_i  in  N_CH  undebounced pin inputs, asynchronous to main_clk.
- level_o  out  N_CH  debounced level.
- rise_o  out  N_CH  one-cycle pulse when level_o goes 0→1.
- fall_o  out  N_CH  one-cycle pulse when level_o goes 1→0.
- repeat_o  out  N_CH  one-cycle auto-repeat pulse while level_o is held at 1.

## Operation
- Per channel: two-flop synchroniser sync1→sync2, a counter cnt of width $clog2(STABLE_CNT+1), and the level register.
- Each cycle, if sync2 == level: cnt ← 0. This covers any glitch, including one cycle before acceptance.
- If sync2 != level and cnt == STABLE_CNT−1: level ← sync2, cnt ← 0, and the matching rise/fall pulse is asserted for that one cycle.
- Otherwise, if sync2 != level: cnt ← cnt+1.
- Counter never exceeds STABLE_CNT−1. No wrap is possible.
- rise_o/fall_o are registered and are never asserted in the same cycle for one channel.
- Channels are fully independent. Simultaneous changes on any subset are each handled in the same cycle.
- Reset values: sync1 = sync2 = level_o = RESET_LEVEL. cnt = 0. rise_o = fall_o = repeat_o = 0. Repeat counters = 0.
- Assertion of rst_n mid-count discards partial counts immediately. No pulse is emitted on reset entry or exit.

## Timing
- Raw change settled before posedge k: sync2 reflects it after posedge k+1. level_o changes after posedge k+1+STABLE_CNT, together with the pulse.
- With STABLE_CNT = 4 and k = 0, level_o changes after posedge 5.
- Minimum accepted pulse width on raw_i is STABLE_CNT cycles. Shorter pulses produce no output activity.
- All outputs come from flops. There is no combinational path from raw_i to any output.

## Configuration
- DEBOUNCE_REPEAT_EN defined:
  - Per-channel repeat counter is active.
  - Accepted rise at cycle r gives repeat_o pulses at r+REPEAT_DELAY, then every REPEAT_PERIOD cycles while level_o = 1.
  - The fall cycle, or any cycle with level_o = 0, clears the counter and suppresses repeat_o in that cycle.
- DEBOUNCE_REPEAT_EN undefined:
  - repeat_o is tied to 0.
  - No repeat counters are generated. The port list is unchanged.

## Structure
- Package debounce_pkg holds:
  - default parameter values;
  - the counter-width function, a $clog2 wrapper guarding STABLE_CNT = 1;
  - the repeat-counter width constant derived from max(REPEAT_DELAY, REPEAT_PERIOD).
- Sub-module debounce_channel implements one channel: synchroniser, stable counter, level and pulse flops, and optional repeat logic.
- debounce_array instantiates N_CH copies in a generate loop and slices RESET_LEVEL per channel.

## Test plan
- Reset with RESET_LEVEL = 9'h005 and raw_i = 0 → level_o = 9'h005 and all pulses 0 during reset. After release, level_o on ch0/ch2 falls after posedge 21 (STABLE_CNT = 20), with fall_o one cycle.
- STABLE_CNT = 4, raw_i[3] rises before posedge 0 and holds → level_o[3] = 1 after posedge 5; rise_o[3] high for exactly that one cycle.
- STABLE_CNT = 4, raw_i[1] high for 3 cycles then low → level_o, rise_o and fall_o stay 0. Repeat with a 1-cycle low glitch after 3 highs, then hold high → acceptance is delayed to 4 cycles after the glitch ends.
- All 9 channels toggle on the same edge → all level_o bits and pulses change in the same cycle.
- DEBOUNCE_REPEAT_EN defined, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, hold ch4 high → repeat_o[4] at rise+10, +13, +16. On release, no repeat_o in the fall cycle or after.
- rst_n asserted while cnt = 3 of 4 → immediate return to reset values. After release, full STABLE_CNT is required again before acceptance.

Source files
------------

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared defaults and width helpers for the debounce array
//
// Purpose: default parameter values and width functions used by
// debounce_array and debounce_channel. No ports.
package debounce_pkg;

  localparam int DEF_N_CH          = 9;
  localparam int DEF_STABLE_CNT    = 20;
  localparam int DEF_REPEAT_DELAY  = 1000;
  localparam int DEF_REPEAT_PERIOD = 200;

  // Stable counter holds 0..STABLE_CNT-1; never let the width collapse to 0.
  function automatic int cnt_width(input int stable_cnt);
    if (stable_cnt <= 1) return 1;
    return $clog2(stable_cnt + 1);
  endfunction

  // Repeat counter holds 0..max(delay, period)-1.
  function automatic int rep_width(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    if (m <= 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced channel with edge pulses and optional auto-repeat
//
// Purpose: two-flop synchroniser, stable-level counter, level register,
// registered rise/fall pulses and (with DEBOUNCE_REPEAT_EN defined) an
// auto-repeat pulse generator.
// Ports:
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset
//   raw_i     - raw pin, asynchronous to clk_i
//   level_o   - debounced level
//   rise_o    - one-cycle pulse on accepted 0->1
//   fall_o    - one-cycle pulse on accepted 1->0
//   repeat_o  - one-cycle auto-repeat pulse while held high (0 without DEBOUNCE_REPEAT_EN)
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CNT  = DEF_STABLE_CNT,
  parameter logic RESET_LEVEL = 1'b0
`ifdef DEBOUNCE_REPEAT_EN
  ,
  parameter int   REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int   REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam int              CW       = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any cycle where the synchronised input matches the accepted level
  // restarts the count, so a glitch even one cycle before acceptance
  // costs a full STABLE_CNT again.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam int            RW          = rep_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          periodic_q, periodic_d;   // first repeat already issued
  logic          repeat_q, repeat_d;

  // Count only on cycles where the level was 1 and stays 1: the rise
  // cycle starts from zero and the fall cycle clears without a pulse.
  always_comb begin
    rep_cnt_d  = rep_cnt_q;
    periodic_d = periodic_q;
    repeat_d   = 1'b0;
    if (level_q && level_d) begin
      if (rep_cnt_q == (periodic_q ? PERIOD_LAST : DELAY_LAST)) begin
        repeat_d   = 1'b1;
        rep_cnt_d  = '0;
        periodic_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end else begin
      rep_cnt_d  = '0;
      periodic_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q  <= '0;
      periodic_q <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      periodic_q <= periodic_d;
      repeat_q   <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_array.sv
// rtl/debounce_array.sv - N_CH-channel debouncer for board switches and buttons
//
// Purpose: instantiates one debounce_channel per raw input. Auto-repeat is
// compiled in only when DEBOUNCE_REPEAT_EN is defined; otherwise repeat_o
// is tied low and the port list is unchanged.
// Ports:
//   main_clk  - system clock (2 kHz)
//   rst_n     - asynchronous active-low reset
//   raw_i     - raw pin inputs, asynchronous to main_clk
//   level_o   - debounced levels
//   rise_o    - one-cycle pulses on accepted 0->1
//   fall_o    - one-cycle pulses on accepted 1->0
//   repeat_o  - one-cycle auto-repeat pulses while held high
module debounce_array
  import debounce_pkg::*;
#(
  parameter int              N_CH          = DEF_N_CH,
  parameter int              STABLE_CNT    = DEF_STABLE_CNT,
  parameter logic [N_CH-1:0] RESET_LEVEL   = {N_CH{1'b0}},
  parameter int              REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int              REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic            main_clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] repeat_o
);

  // Elaboration-time guard on parameter ranges.
  if (STABLE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("debounce_array: STABLE_CNT, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT    (STABLE_CNT),
      .RESET_LEVEL   (RESET_LEVEL[g])
`ifdef DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk_i    (main_clk),
      .rst_ni   (rst_n),
      .raw_i    (raw_i[g]),
      .level_o  (level_o[g]),
      .rise_o   (rise_o[g]),
      .fall_o   (fall_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

endmodule

// File: tb/tb_debounce_array.sv
// tb/tb_debounce_array.sv - directed self-checking bench for debounce_array
//
// Two instances: u_dut20 (STABLE_CNT=20, RESET_LEVEL=9'h005) for the reset
// release behaviour, u_dut4 (STABLE_CNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
// for the remaining cases. Repeat expectations follow DEBOUNCE_REPEAT_EN.
module tb_debounce_array;

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic       main_clk;
  logic       rst_n;
  logic [8:0] raw20, lvl20, rise20, fall20, rep20;
  logic [8:0] raw4,  lvl4,  rise4,  fall4,  rep4;

  int tests = 0;
  int fails = 0;

  debounce_array #(
    .N_CH(9), .STABLE_CNT(20), .RESET_LEVEL(9'h005),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_dut20 (
    .main_clk(main_clk), .rst_n(rst_n), .raw_i(raw20),
    .level_o(lvl20), .rise_o(rise20), .fall_o(fall20), .repeat_o(rep20)
  );

  debounce_array #(
    .N_CH(9), .STABLE_CNT(4), .RESET_LEVEL(9'h000),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_dut4 (
    .main_clk(main_clk), .rst_n(rst_n), .raw_i(raw4),
    .level_o(lvl4), .rise_o(rise4), .fall_o(fall4), .repeat_o(rep4)
  );

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n posedges and settle 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge main_clk);
    #1;
  endtask

  initial begin
    logic [8:0] act;
    logic [8:0] rep_exp;
    logic [8:0] zero9;
    zero9 = '0;

    // Reset state
    rst_n = 1'b0;
    raw20 = '0;
    raw4  = '0;
    step(3);
    chk("rst_lvl20",   lvl20, 9'h005);
    chk("rst_pulse20", rise20 | fall20 | rep20, zero9);
    chk("rst_lvl4",    lvl4, zero9);
    chk("rst_pulse4",  rise4 | fall4 | rep4, zero9);

    // Release: ch0/ch2 of u_dut20 fall after posedge 21
    rst_n = 1'b1;
    step(21);
    chk("lvl20_hold",   lvl20, 9'h005);
    chk("pulse20_none", rise20 | fall20, zero9);
    step(1);
    chk("lvl20_fall",   lvl20, zero9);
    chk("fall20",       fall20, 9'h005);
    chk("rise20_quiet", rise20, zero9);
    step(1);
    chk("fall20_one",   fall20, zero9);

    // Single channel rise, accepted after posedge 5
    raw4[3] = 1'b1;
    step(5);
    chk("ch3_pre",  lvl4, zero9);
    step(1);
    chk("ch3_lvl",  lvl4, 9'h008);
    chk("ch3_rise", rise4, 9'h008);
    chk("ch3_nofall", fall4, zero9);
    raw4[3] = 1'b0;
    step(1);
    chk("ch3_rise_one", rise4, zero9);
    step(5);
    chk("ch3_lvl_low", lvl4, zero9);
    chk("ch3_fall",    fall4, 9'h008);

    // Three-cycle pulse is rejected
    act = '0;
    raw4[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      act |= lvl4 | rise4 | fall4;
    end
    raw4[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      act |= lvl4 | rise4 | fall4;
    end
    chk("short_pulse", act, zero9);

    // Three highs, one-cycle low glitch, then hold: full count restarts
    raw4[1] = 1'b1;
    step(3);
    raw4[1] = 1'b0;
    step(1);
    raw4[1] = 1'b1;
    step(5);
    chk("glitch_pre",  lvl4, zero9);
    step(1);
    chk("glitch_lvl",  lvl4, 9'h002);
    chk("glitch_rise", rise4, 9'h002);
    raw4[1] = 1'b0;
    step(6);
    chk("glitch_fall", fall4, 9'h002);

    // All channels toggle together
    raw4 = 9'h1FF;
    step(5);
    chk("all_pre",    lvl4, zero9);
    step(1);
    chk("all_lvl",    lvl4, 9'h1FF);
    chk("all_rise",   rise4, 9'h1FF);
    chk("all_nofall", fall4, zero9);
    raw4 = 9'h000;
    step(6);
    chk("all_lvl_low", lvl4, zero9);
    chk("all_fall",    fall4, 9'h1FF);
    chk("all_norise",  rise4, zero9);

    // Auto-repeat on ch4: rise at posedge 5, repeats at 15,18,21,24,27;
    // release after posedge 24 makes posedge 30 the fall cycle (no repeat).
    raw4[4] = 1'b1;
    step(6);
    chk("rep_rise", rise4, 9'h010);
    for (int j = 6; j <= 35; j++) begin
      step(1);
      rep_exp = (REP_ON && (j == 15 || j == 18 || j == 21 || j == 24 || j == 27))
                ? 9'h010 : 9'h000;
      chk($sformatf("rep_p%0d", j), rep4, rep_exp);
      if (j == 24) raw4[4] = 1'b0;
      if (j == 29) chk("rep_lvl_held", lvl4, 9'h010);
      if (j == 30) begin
        chk("rep_lvl_fall", lvl4, zero9);
        chk("rep_fall",     fall4, 9'h010);
      end
    end

    // Reset mid-count (cnt = 3 of 4) applies immediately; full count needed again
    raw4[5] = 1'b1;
    step(5);
    rst_n = 1'b0;
    #1;
    chk("async_lvl20",  lvl20, 9'h005);
    chk("async_lvl4",   lvl4, zero9);
    chk("async_pulse4", rise4 | fall4 | rep4, zero9);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("rst_recount_pre",  lvl4, zero9);
    step(1);
    chk("rst_recount_lvl",  lvl4, 9'h020);
    chk("rst_recount_rise", rise4, 9'h020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
